// File: rtl/add_sub_pipe32.sv
// Two-stage pipelined adder/subtractor: stage 1 forms bit and 4-bit group propagate/generate,
// stage 2 resolves carries with a two-level group lookahead and registers sum and flags.
module add_sub_pipe32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             overflow
);
  localparam int NG  = WIDTH / 4;
  localparam int NB  = (NG + 3) / 4;
  localparam int NGP = NB * 4;

  // {P, G} of a 4-wide lookahead slice
  function automatic logic [1:0] pg4(input logic [3:0] g, input logic [3:0] p);
    logic pp, gg;
    pp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {pp, gg};
  endfunction

  // Carries into positions 1..3 of a 4-wide slice, flattened sum-of-products form
  function automatic logic [2:0] cla3(input logic [2:0] g, input logic [2:0] p, input logic c);
    logic [2:0] r;
    r[0] = g[0] | (p[0] & c);
    r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return r;
  endfunction

  logic             w_in_xfer, w_out_xfer, w_s2_load;
  logic [WIDTH-1:0] w_bb, w_p, w_g;
  logic [NG-1:0]    w_grp_p, w_grp_g;

  logic [WIDTH-1:0] r_p, r_g;
  logic [NG-1:0]    r_grp_p, r_grp_g;
  logic             r_cin, r_a_msb, r_bb_msb, r_v1;

  logic [NGP-1:0]   w_gp_pad, w_gg_pad;
  logic [NB-1:0]    w_blk_p, w_blk_g;
  logic [NB:0]      w_blk_c;
  logic [NGP-1:0]   w_grp_c;
  logic [WIDTH-1:0] w_c, w_sum;
  logic             w_acc, w_prod, w_ovf, w_unused_g3;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry, r_ovf, r_v2;

  assign w_s2_load  = r_v1 && (!r_v2 || out_ready);
  assign in_ready   = !r_v1 || w_s2_load;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_v2 && out_ready;

  assign w_bb = sub ? ~b : b;
  assign w_p  = a ^ w_bb;
  assign w_g  = a & w_bb;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_s1_grp
      assign {w_grp_p[gi], w_grp_g[gi]} = pg4(w_g[4*gi +: 4], w_p[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    w_gp_pad = '0;
    w_gg_pad = '0;
    w_gp_pad[NG-1:0] = r_grp_p;
    w_gg_pad[NG-1:0] = r_grp_g;
  end

  generate
    for (gi = 0; gi < NB; gi++) begin : g_s2_blk
      assign {w_blk_p[gi], w_blk_g[gi]} = pg4(w_gg_pad[4*gi +: 4], w_gp_pad[4*gi +: 4]);
      assign w_grp_c[4*gi] = w_blk_c[gi];
      assign w_grp_c[4*gi+1 +: 3] = cla3(w_gg_pad[4*gi +: 3], w_gp_pad[4*gi +: 3], w_blk_c[gi]);
    end
  endgenerate

  // Top-level block carries, each expanded as an independent product sum (no ripple)
  always_comb begin
    w_blk_c    = '0;
    w_blk_c[0] = r_cin;
    w_acc      = 1'b0;
    w_prod     = 1'b1;
    for (int j = 0; j < NB; j++) begin
      w_acc  = 1'b0;
      w_prod = 1'b1;
      for (int i = j; i >= 0; i--) begin
        w_acc  = w_acc | (w_prod & w_blk_g[i]);
        w_prod = w_prod & w_blk_p[i];
      end
      w_blk_c[j+1] = w_acc | (w_prod & r_cin);
    end
  end

  generate
    for (gi = 0; gi < NG; gi++) begin : g_s2_bit
      assign w_c[4*gi]        = w_grp_c[gi];
      assign w_c[4*gi+1 +: 3] = cla3(r_g[4*gi +: 3], r_p[4*gi +: 3], w_grp_c[gi]);
    end
  endgenerate

  // The top g bit of each group only matters through the registered group G
  always_comb begin
    w_unused_g3 = 1'b0;
    for (int k = 0; k < NG; k++) w_unused_g3 = w_unused_g3 ^ r_g[4*k+3];
  end

  assign w_sum = r_p ^ w_c;
  assign w_ovf = (r_a_msb == r_bb_msb) && (w_sum[WIDTH-1] != r_a_msb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p      <= '0;
      r_g      <= '0;
      r_grp_p  <= '0;
      r_grp_g  <= '0;
      r_cin    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_bb_msb <= 1'b0;
      r_v1     <= 1'b0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_v2     <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_p      <= w_p;
        r_g      <= w_g;
        r_grp_p  <= w_grp_p;
        r_grp_g  <= w_grp_g;
        r_cin    <= sub;
        r_a_msb  <= a[WIDTH-1];
        r_bb_msb <= w_bb[WIDTH-1];
      end
      r_v1 <= w_in_xfer ? 1'b1 : (w_s2_load ? 1'b0 : r_v1);
      if (w_s2_load) begin
        r_sum   <= w_sum;
        r_carry <= w_blk_c[NB];
        r_ovf   <= w_ovf;
      end
      r_v2 <= w_s2_load ? 1'b1 : (w_out_xfer ? 1'b0 : r_v2);
    end
  end

  assign out_valid = r_v2;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = (r_sum == '0);
  assign sign      = r_sum[WIDTH-1];

endmodule

// File: tb/tb_add_sub_pipe32.sv
// Directed and random bench for add_sub_pipe32: corner vectors, latency, backpressure,
// asynchronous reset mid-stream and a random valid/ready stream against a scoreboard.
module tb_add_sub_pipe32;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic        carry, zero, sign, overflow;
  logic [31:0] a, b, sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  f;   // {carry, zero, sign, overflow}
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [31:0] sum;
    logic [3:0]  f;
  } vec_t;

  exp_t q[$];
  exp_t drv_exp;
  exp_t none_exp = '{32'd0, 4'd0};

  vec_t cv[10] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b1100},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0011},
    '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 4'b0010},
    '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b1001},
    '{32'h00000009, 32'h00000009, 1'b1, 32'h00000000, 4'b1100},
    '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 4'b0000},
    '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 4'b0010},
    '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0100},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b1101},
    '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b0010}
  };

  add_sub_pipe32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .zero(zero), .sign(sign), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t        e;
    logic [32:0] w;
    longint      sr;
    if (s) begin
      e.sum  = x - y;
      e.f[3] = (x >= y);
      sr     = longint'($signed(x)) - longint'($signed(y));
    end else begin
      w      = {1'b0, x} + {1'b0, y};
      e.sum  = w[31:0];
      e.f[3] = w[32];
      sr     = longint'($signed(x)) + longint'($signed(y));
    end
    e.f[2] = (e.sum == 32'd0);
    e.f[1] = e.sum[31];
    e.f[0] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  // Called at the falling edge; data goes to X whenever in_valid is low
  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input logic ordy, input exp_t e);
    in_valid  = v;
    a         = v ? x : 'x;
    b         = v ? y : 'x;
    sub       = v ? s : 1'bx;
    out_ready = ordy;
    drv_exp   = e;
    #1;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL %s_extra observed=result expected=none", tag);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({tag, "_sum"}, sum, e.sum);
        chk({tag, "_flags"}, {28'd0, carry, zero, sign, overflow}, {28'd0, e.f});
      end
    end
    if (in_valid && in_ready) q.push_back(drv_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          idx, accepted, cycles;
    logic        acc, v, ordy, s;
    logic [31:0] x, y, hold_sum;
    logic [3:0]  hold_f;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {28'd0, carry, zero, sign, overflow}, 32'h4);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Back-to-back corner vectors; first result two edges after acceptance
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, cv[i].x, cv[i].y, cv[i].s, 1'b1, '{cv[i].sum, cv[i].f});
      chk("corner_in_ready", {31'd0, in_ready}, 32'd1);
      if (i == 1) chk("latency_not_early", {31'd0, out_valid}, 32'd0);
      if (i >= 2) chk("stream_valid", {31'd0, out_valid}, 32'd1);
      tick("corner");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none_exp);
      tick("corner");
    end
    chk("corner_drained", 32'(q.size()), 32'd0);

    // Backpressure: five cycles with out_ready low, then release
    idx = 0; accepted = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      x = 32'h11111111 * (idx + 1); y = 32'h01010101 * (idx + 3); s = idx[0];
      drive(1'b1, x, y, s, 1'b0, model(x, y, s));
      acc = in_ready;
      if (cyc >= 2) begin
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      if (cyc == 2) begin
        hold_sum = sum;
        hold_f   = {carry, zero, sign, overflow};
      end
      if (cyc > 2) begin
        chk("bp_sum_stable", sum, hold_sum);
        chk("bp_flags_stable", {28'd0, carry, zero, sign, overflow}, {28'd0, hold_f});
      end
      tick("bp");
      if (acc) begin idx++; accepted++; end
    end
    chk("bp_accepted", 32'(accepted), 32'd2);
    for (int cyc = 0; cyc < 20 && accepted < 6; cyc++) begin
      x = 32'h11111111 * (idx + 1); y = 32'h01010101 * (idx + 3); s = idx[0];
      drive(1'b1, x, y, s, 1'b1, model(x, y, s));
      acc = in_ready;
      tick("bp_drain");
      if (acc) begin idx++; accepted++; end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none_exp);
      tick("bp_drain");
    end
    chk("bp_total_accepted", 32'(accepted), 32'd6);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset with two operations in flight
    drive(1'b1, 32'h00000003, 32'h00000004, 1'b0, 1'b0, model(32'h3, 32'h4, 1'b0));
    tick("rst_fill");
    drive(1'b1, 32'h00000010, 32'h00000001, 1'b1, 1'b0, model(32'h10, 32'h1, 1'b1));
    tick("rst_fill");
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, none_exp);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum", sum, 32'd0);
    chk("async_rst_flags", {28'd0, carry, zero, sign, overflow}, 32'h4);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none_exp);
      chk("no_stale_result", {31'd0, out_valid}, 32'd0);
      tick("post_rst");
    end
    drive(1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b1, '{32'h01234567, 4'b1000});
    tick("post_rst");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none_exp);
      tick("post_rst");
    end
    chk("post_rst_drained", 32'(q.size()), 32'd0);

    // Random valid/ready stream against the model
    accepted = 0; cycles = 0;
    while (accepted < 10000 && cycles < 40000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      x    = $urandom;
      y    = $urandom;
      if ($urandom_range(0, 7) == 0) y = ~x;
      if ($urandom_range(0, 7) == 0) y = x;
      s    = 1'($urandom_range(0, 1));
      drive(v, x, y, s, ordy, model(x, y, s));
      acc = in_valid && in_ready;
      tick("rand");
      if (acc) accepted++;
      cycles++;
    end
    chk("rand_accepted", 32'(accepted), 32'd10000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, none_exp);
      tick("rand");
    end
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
